// File: rtl/mul_div_seq.sv
// mul_div_seq: sequential unsigned multiply/divide unit.
// One pass through the shared add/subtract path (sel=1 add, sel=0 subtract)
// per cycle: shift-and-add for multiply, restoring subtract-and-shift for divide.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only in IDLE or DONE
//   op         1 = multiply, 0 = divide (sampled with start)
//   a, b       multiplier/dividend, multiplicand/divisor
//   busy       high while iterating (MUL/DIV)
//   done       one-cycle completion pulse
//   result_hi  product[2W-1:W] or remainder
//   result_lo  product[W-1:0] or quotient
//   div_zero   divide-by-zero flag
//
// Build option: define MUL_DIV_DIVZERO_EN to short-circuit divide by zero to
// DONE in one cycle and raise div_zero. Without it the divisor is not checked
// and div_zero is always 0; result values are the same in both builds.
//
// state  | meaning
// IDLE   | waiting for start
// MUL    | shift-and-add iteration
// DIV    | restoring divide iteration
// DONE   | one-cycle done pulse, results valid; start accepted here too

module mul_div_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q;    // hi half of product, or remainder
  logic [WIDTH-1:0] lo_q;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor
  logic [CW-1:0]    count_q;
  logic             dz_q;

  logic             accept;
  logic             dz_hit;
  logic             alu_sel;
  logic [WIDTH:0]   alu_x, alu_y, alu_r;
  logic [WIDTH:0]   mul_sum;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

`ifdef MUL_DIV_DIVZERO_EN
  assign dz_hit = !op && (b == '0);
`else
  assign dz_hit = 1'b0;
`endif

  // Shared 65-bit add/subtract path. In DIV the minuend is the remainder
  // after the {rem, quo} << 1 step; bit WIDTH of the result is the borrow.
  always_comb begin
    alu_sel = 1'b1;
    alu_x   = {1'b0, opnd_q};
    alu_y   = {1'b0, acc_q};
    if (state_q == S_DIV) begin
      alu_sel = 1'b0;
      alu_x   = {acc_q, lo_q[WIDTH-1]};
      alu_y   = {1'b0, opnd_q};
    end
    alu_r = alu_sel ? (alu_x + alu_y) : (alu_x - alu_y);
  end

  // Carry kept in bit WIDTH so the right shift moves it into the top of hi.
  assign mul_sum = lo_q[0] ? alu_r : {1'b0, acc_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = dz_hit ? S_DONE : (op ? S_MUL : S_DIV);
      end
      S_MUL: begin
        busy = 1'b1;
        if (count_q == LAST) state_d = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (count_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = dz_hit ? S_DONE : (op ? S_MUL : S_DIV);
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      count_q <= '0;
      dz_q    <= 1'b0;
    end else if (accept) begin
      count_q <= '0;
      dz_q    <= dz_hit;
      opnd_q  <= b;
      // Divide-by-zero short circuit produces the same values the full
      // restoring pass would: quotient all ones, remainder = dividend.
      acc_q   <= dz_hit ? a : '0;
      lo_q    <= dz_hit ? '1 : a;
    end else if (state_q == S_MUL) begin
      acc_q   <= mul_sum[WIDTH:1];
      lo_q    <= {mul_sum[0], lo_q[WIDTH-1:1]};
      count_q <= count_q + 1'b1;
    end else if (state_q == S_DIV) begin
      if (!alu_r[WIDTH]) begin
        acc_q <= alu_r[WIDTH-1:0];
        lo_q  <= {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_q <= alu_x[WIDTH-1:0];
        lo_q  <= {lo_q[WIDTH-2:0], 1'b0};
      end
      count_q <= count_q + 1'b1;
    end
  end

  assign result_hi = acc_q;
  assign result_lo = lo_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed and random bench for mul_div_seq.
module tb_mul_div_seq;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [63:0] a, b;
  logic        busy, done, div_zero;
  logic [63:0] result_hi, result_lo;

  int checks   = 0;
  int failures = 0;

  mul_div_seq #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start; lat = edges after the accepting edge until done is seen
  // (200 = timed out), bcnt = samples with busy high before done.
  task automatic run_op(input logic o, input logic [63:0] x, input logic [63:0] y,
                        output int lat, output int bcnt);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_divzero got=%b exp=0", div_zero); end
    checks++; if (result_hi !== 64'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", result_hi); end
    checks++; if (result_lo !== 64'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", result_lo); end
  endtask

  task automatic test_mul_max();
    int lat, bcnt;
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, bcnt);
    checks++; if (lat != 64) begin failures++; $display("FAIL mul_max_latency got=%0d exp=64", lat); end
    checks++; if (bcnt != 64) begin failures++; $display("FAIL mul_max_busy got=%0d exp=64", bcnt); end
    checks++; if (result_hi !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mul_max_hi got=%h exp=fffffffffffffffe", result_hi); end
    checks++; if (result_lo !== 64'h1) begin failures++; $display("FAIL mul_max_lo got=%h exp=1", result_lo); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got done=%b busy=%b exp=0 0", done, busy); end
    checks++; if (result_hi !== 64'hFFFF_FFFF_FFFF_FFFE || result_lo !== 64'h1) begin failures++; $display("FAIL mul_hold got=%h_%h", result_hi, result_lo); end
  endtask

  task automatic test_div();
    int lat, bcnt;
    run_op(1'b0, 64'd100, 64'd7, lat, bcnt);
    checks++; if (lat != 64) begin failures++; $display("FAIL div_latency got=%0d exp=64", lat); end
    checks++; if (result_lo !== 64'd14 || result_hi !== 64'd2) begin failures++; $display("FAIL div_100_7 got q=%0d r=%0d exp q=14 r=2", result_lo, result_hi); end
    tick();
    run_op(1'b0, 64'd5, 64'd9, lat, bcnt);
    checks++; if (lat != 64 || result_lo !== 64'd0 || result_hi !== 64'd5) begin failures++; $display("FAIL div_5_9 got lat=%0d q=%0d r=%0d exp 64 0 5", lat, result_lo, result_hi); end
    tick();
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    int exp_lat;
    logic exp_dz;
`ifdef MUL_DIV_DIVZERO_EN
    exp_lat = 0; exp_dz = 1'b1;
`else
    exp_lat = 64; exp_dz = 1'b0;
`endif
    run_op(1'b0, 64'h1234, 64'h0, lat, bcnt);
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL divzero_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (div_zero !== exp_dz) begin failures++; $display("FAIL divzero_flag got=%b exp=%b", div_zero, exp_dz); end
    checks++; if (result_lo !== 64'hFFFF_FFFF_FFFF_FFFF || result_hi !== 64'h1234) begin failures++; $display("FAIL divzero_result got q=%h r=%h exp q=ffffffffffffffff r=1234", result_lo, result_hi); end
    tick();
    checks++; if (div_zero !== exp_dz) begin failures++; $display("FAIL divzero_hold got=%b exp=%b", div_zero, exp_dz); end
    run_op(1'b1, 64'd2, 64'd3, lat, bcnt);
    checks++; if (div_zero !== 1'b0 || result_lo !== 64'd6) begin failures++; $display("FAIL divzero_clear got dz=%b lo=%0d exp 0 6", div_zero, result_lo); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, ndone, edges;
    op = 1'b1; a = 64'd3; b = 64'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    op = 1'b0; a = 64'd10; b = 64'd3; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 11; ndone = 0;
    while (done !== 1'b1 && lat < 200) begin tick(); lat++; end
    checks++; if (lat != 64) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=64", lat); end
    checks++; if (result_lo !== 64'd12 || result_hi !== 64'd0) begin failures++; $display("FAIL busy_ignore_result got=%h_%h exp=0_c", result_hi, result_lo); end
    op = 1'b0; a = 64'd50; b = 64'd6; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (done !== 1'b1 && edges < 200) begin
      tick(); edges++;
    end
    checks++; if (edges != 65) begin failures++; $display("FAIL back_to_back_spacing got=%0d exp=65", edges); end
    checks++; if (result_lo !== 64'd8 || result_hi !== 64'd2) begin failures++; $display("FAIL back_to_back_result got q=%0d r=%0d exp 8 2", result_lo, result_hi); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL back_to_back_extra_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, ndone;
    op = 1'b1; a = 64'hDEAD_BEEF; b = 64'h1234_5678; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || result_hi !== 64'h0 || result_lo !== 64'h0)
      begin failures++; $display("FAIL reset_mid_outputs got busy=%b done=%b dz=%b hi=%h lo=%h exp all 0", busy, done, div_zero, result_hi, result_lo); end
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      tick();
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL reset_mid_activity got=%0d exp=0", ndone); end
    run_op(1'b1, 64'd6, 64'd7, lat, bcnt);
    checks++; if (lat != 64 || result_lo !== 64'd42 || result_hi !== 64'd0) begin failures++; $display("FAIL reset_mid_after got lat=%0d lo=%0d exp 64 42", lat, result_lo); end
    tick();
    rst = 1'b1; start = 1'b1; op = 1'b1; a = 64'd9; b = 64'd9;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || result_lo !== 64'h0) begin failures++; $display("FAIL reset_start_same_edge got busy=%b lo=%h exp 0 0", busy, result_lo); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_start_idle got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic        o;
    logic [63:0] x, y, eh, el;
    logic [127:0] prod;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      y = (i % 4 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      if (i % 8 == 1) x = 64'($urandom);
      if (y == 64'h0) y = 64'd1;
      o = 1'($urandom_range(0, 1));
      if (o) begin
        prod = {64'h0, x} * {64'h0, y};
        eh = prod[127:64]; el = prod[63:0];
      end else begin
        eh = x % y; el = x / y;
      end
      run_op(o, x, y, lat, bcnt);
      checks++;
      if (lat != 64 || result_hi !== eh || result_lo !== el) begin
        failures++;
        $display("FAIL random_%0d op=%b a=%h b=%h got lat=%0d hi=%h lo=%h exp lat=64 hi=%h lo=%h",
                 i, o, x, y, lat, result_hi, result_lo, eh, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_max();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
